// File: rtl/cam_update_ctrl_pkg.sv
// Shared definitions for the CAM update controller: the command opcode.
package cam_update_ctrl_pkg;

  typedef enum logic [1:0] {
    INSERT     = 2'd0,
    INVALIDATE = 2'd1,
    FLUSH      = 2'd2
  } cam_op_t;

endpackage

// File: rtl/cam_update_ctrl_prio_enc.sv
// Lowest-index priority encoder: reports the first set bit of req and whether any bit is set.
module cam_update_ctrl_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_update_ctrl.sv
// CAM update controller: probes the CAM before every insert/invalidate, picks a victim
// slot on insert misses, sequences flushes and tracks a shadow copy of the valid bits.
module cam_update_ctrl
  import cam_update_ctrl_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int KEY_WIDTH   = 32,
  parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  // Command channel: a command transfers on a cycle with req_valid && req_ready;
  // req_ready is only high in IDLE, so at most one command is ever in flight.
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  output logic [KEY_WIDTH-1:0]   lookup_key,
  input  logic                   lookup_hit,
  input  logic [INDEX_WIDTH-1:0] lookup_idx,
  output logic                   update_en,
  output logic [KEY_WIDTH-1:0]   update_key,
  output logic [INDEX_WIDTH-1:0] update_idx,
  output logic                   update_valid,
  output logic                   done_valid,
  output logic                   done_hit,
  output logic [INDEX_WIDTH-1:0] done_idx,
  output logic [INDEX_WIDTH:0]   num_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_WRITE = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  cam_op_t                op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [INDEX_WIDTH-1:0] tgt_q, tgt_d;
  logic                   evict_q, evict_d;
  logic [INDEX_WIDTH-1:0] rr_q, rr_d;
  logic [INDEX_WIDTH-1:0] fidx_q, fidx_d;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [INDEX_WIDTH:0]   cnt_q, cnt_d;

  logic [INDEX_WIDTH-1:0] free_idx;
  logic                   free_found;

  cam_update_ctrl_prio_enc #(
    .N (NUM_ENTRIES),
    .W (INDEX_WIDTH)
  ) u_free_enc (
    .req   (~valid_q),
    .idx   (free_idx),
    .found (free_found)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    key_d        = key_q;
    tgt_d        = tgt_q;
    evict_d      = evict_q;
    rr_d         = rr_q;
    fidx_d       = fidx_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    req_ready    = 1'b0;
    lookup_key   = key_q;
    update_en    = 1'b0;
    update_key   = '0;
    update_idx   = '0;
    update_valid = 1'b0;
    done_valid   = 1'b0;
    done_hit     = 1'b0;
    done_idx     = '0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = cam_op_t'(req_op);
          key_d   = req_key;
          fidx_d  = '0;
          state_d = (cam_op_t'(req_op) == FLUSH) ? S_FLUSH : S_PROBE;
        end
      end

      S_PROBE: begin
        if (op_q == INSERT) begin
          if (lookup_hit) begin
            done_valid = 1'b1;
            done_hit   = 1'b1;
            done_idx   = lookup_idx;
            state_d    = S_IDLE;
          end else begin
            // Prefer an empty slot; only evict the round-robin slot when the table is full.
            tgt_d   = free_found ? free_idx : rr_q;
            evict_d = !free_found;
            state_d = S_WRITE;
          end
        end else if (lookup_hit) begin
          tgt_d   = lookup_idx;
          evict_d = 1'b0;
          state_d = S_WRITE;
        end else begin
          done_valid = 1'b1;
          state_d    = S_IDLE;
        end
      end

      S_WRITE: begin
        update_en    = 1'b1;
        update_idx   = tgt_q;
        update_key   = key_q;
        update_valid = (op_q == INSERT);
        done_valid   = 1'b1;
        done_hit     = (op_q != INSERT);
        done_idx     = tgt_q;
        if (evict_q) begin
          rr_d = rr_q + INDEX_WIDTH'(1);
        end
        state_d = S_IDLE;
      end

      S_FLUSH: begin
        update_en  = 1'b1;
        update_idx = fidx_q;
        if (fidx_q == INDEX_WIDTH'(NUM_ENTRIES - 1)) begin
          done_valid = 1'b1;
          state_d    = S_IDLE;
        end else begin
          fidx_d = fidx_q + INDEX_WIDTH'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Shadow valid bits and occupancy follow every CAM write.
    if (update_en) begin
      valid_d[update_idx] = update_valid;
      if (update_valid && !valid_q[update_idx]) begin
        cnt_d = cnt_q + (INDEX_WIDTH + 1)'(1);
      end else if (!update_valid && valid_q[update_idx]) begin
        cnt_d = cnt_q - (INDEX_WIDTH + 1)'(1);
      end
    end

    // A reset cycle aborts whatever is in flight: no write and no completion escape.
    if (reset) begin
      req_ready    = 1'b0;
      update_en    = 1'b0;
      update_valid = 1'b0;
      done_valid   = 1'b0;
      done_hit     = 1'b0;
      done_idx     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= INSERT;
      key_q   <= '0;
      tgt_q   <= '0;
      evict_q <= 1'b0;
      rr_q    <= '0;
      fidx_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      key_q   <= key_d;
      tgt_q   <= tgt_d;
      evict_q <= evict_d;
      rr_q    <= rr_d;
      fidx_q  <= fidx_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign num_valid = cnt_q;

endmodule

// File: tb/tb_cam_update_ctrl.sv
// Bench for cam_update_ctrl: emulates the CAM, predicts each command's cycle-by-cycle
// outputs from a transaction-level model and checks them, plus hand-computed spot checks.
module tb_cam_update_ctrl;
  import cam_update_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int KW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'd0;
  logic [KW-1:0] req_key = '0;
  logic [KW-1:0] lookup_key;
  logic          lookup_hit;
  logic [IW-1:0] lookup_idx;
  logic          update_en;
  logic [KW-1:0] update_key;
  logic [IW-1:0] update_idx;
  logic          update_valid;
  logic          done_valid;
  logic          done_hit;
  logic [IW-1:0] done_idx;
  logic [IW:0]   num_valid;

  cam_update_ctrl #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .lookup_key(lookup_key), .lookup_hit(lookup_hit), .lookup_idx(lookup_idx),
    .update_en(update_en), .update_key(update_key), .update_idx(update_idx),
    .update_valid(update_valid),
    .done_valid(done_valid), .done_hit(done_hit), .done_idx(done_idx), .num_valid(num_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- CAM emulation (shares reset with the DUT) ----------------
  logic          cam_vld[N];
  logic [KW-1:0] cam_key[N];

  always_comb begin
    lookup_hit = 1'b0;
    lookup_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (cam_vld[i] && cam_key[i] == lookup_key) begin
        lookup_hit = 1'b1;
        lookup_idx = IW'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cam_vld[i] <= 1'b0;
    end else if (update_en) begin
      cam_vld[update_idx] <= update_valid;
      cam_key[update_idx] <= update_key;
    end
  end

  // ---------------- model and scoreboard ----------------
  typedef struct packed {
    logic          upd;
    logic [IW-1:0] idx;
    logic          val;
    logic [KW-1:0] key;
    logic          dv;
    logic          dh;
    logic [IW-1:0] di;
    logic [IW:0]   nv;
  } exp_t;

  exp_t          exp_q[$];
  logic          mdl_vld[N];
  logic [KW-1:0] mdl_key[N];
  int            mdl_ptr;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_log[$];
  logic val_log[$];
  int done_cnt = 0;
  int last_done_cyc = 0;
  int last_done_hit = 0;
  int last_done_idx = 0;
  int acc_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mdl_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (mdl_vld[i]) c++;
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mdl_vld[i] = 1'b0;
      mdl_key[i] = '0;
    end
    mdl_ptr = 0;
  endfunction

  function automatic exp_t mk(logic upd, int idx, logic val, logic [KW-1:0] key,
                              logic dv, logic dh, int di);
    exp_t e;
    e.upd = upd; e.idx = IW'(idx); e.val = val; e.key = key;
    e.dv = dv; e.dh = dh; e.di = IW'(di); e.nv = (IW+1)'(mdl_count());
    return e;
  endfunction

  // One expected entry per cycle following the accept edge.
  function automatic void model_accept(cam_op_t op, logic [KW-1:0] key);
    int hit_i = -1;
    int victim = -1;
    for (int i = 0; i < N; i++) if (mdl_vld[i] && mdl_key[i] == key) hit_i = i;
    case (op)
      INSERT: begin
        if (hit_i >= 0) begin
          exp_q.push_back(mk(0, 0, 0, '0, 1, 1, hit_i));
        end else begin
          for (int i = 0; i < N; i++) if (!mdl_vld[i] && victim < 0) victim = i;
          exp_q.push_back(mk(0, 0, 0, '0, 0, 0, 0));
          exp_q.push_back(mk(1, (victim < 0) ? mdl_ptr : victim, 1, key, 1, 0,
                             (victim < 0) ? mdl_ptr : victim));
          if (victim < 0) begin
            victim  = mdl_ptr;
            mdl_ptr = (mdl_ptr + 1) % N;
          end
          mdl_vld[victim] = 1'b1;
          mdl_key[victim] = key;
        end
      end
      INVALIDATE: begin
        if (hit_i >= 0) begin
          exp_q.push_back(mk(0, 0, 0, '0, 0, 0, 0));
          exp_q.push_back(mk(1, hit_i, 0, '0, 1, 1, hit_i));
          mdl_vld[hit_i] = 1'b0;
        end else begin
          exp_q.push_back(mk(0, 0, 0, '0, 1, 0, 0));
        end
      end
      default: begin
        for (int i = 0; i < N; i++) begin
          exp_q.push_back(mk(1, i, 0, '0, (i == N - 1), 0, 0));
          mdl_vld[i] = 1'b0;
        end
      end
    endcase
  endfunction

  // Compare process: 2 time units after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    int bad;
    int dups;
    #2;
    if (update_en) begin
      wr_log.push_back(int'(update_idx));
      val_log.push_back(update_valid);
    end
    if (done_valid) begin
      done_cnt++;
      last_done_cyc = cyc;
      last_done_hit = int'(done_hit);
      last_done_idx = int'(done_idx);
    end
    if (reset) begin
      check("rst_update_en", update_en, 0);
      check("rst_done_valid", done_valid, 0);
      check("rst_done_hit", done_hit, 0);
      check("rst_done_idx", done_idx, 0);
      check("rst_req_ready", req_ready, 0);
      exp_q.delete();
      model_reset();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("busy_req_ready", req_ready, 0);
      check("update_en", update_en, e.upd);
      if (e.upd) begin
        check("update_idx", update_idx, e.idx);
        check("update_valid", update_valid, e.val);
        if (e.val) check("update_key", update_key, e.key);
      end
      check("done_valid", done_valid, e.dv);
      if (e.dv) begin
        check("done_hit", done_hit, e.dh);
        check("done_idx", done_idx, e.di);
      end
      check("busy_num_valid", num_valid, e.nv);
    end else begin
      check("idle_req_ready", req_ready, 1);
      check("idle_update_en", update_en, 0);
      check("idle_done_valid", done_valid, 0);
      check("idle_num_valid", num_valid, mdl_count());
      bad = 0;
      dups = 0;
      for (int i = 0; i < N; i++) begin
        if (cam_vld[i] !== mdl_vld[i]) bad++;
        else if (mdl_vld[i] && cam_key[i] !== mdl_key[i]) bad++;
        for (int j = i + 1; j < N; j++)
          if (cam_vld[i] && cam_vld[j] && cam_key[i] == cam_key[j]) dups++;
      end
      check("cam_consistent", bad, 0);
      check("dup_keys", dups, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input cam_op_t op, input logic [KW-1:0] key, output bit ok);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ok = req_ready;
    if (!ok) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
    end else begin
      acc_cyc = cyc;
      model_accept(op, key);
    end
  endtask

  task automatic do_cmd(input cam_op_t op, input logic [KW-1:0] key);
    bit ok;
    int guard = 0;
    start_cmd(op, key, ok);
    if (ok) begin
      @(negedge clk);
      req_valid = 1'b0;
      while (exp_q.size() != 0 && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] idx_pack();
    logic [31:0] p = '0;
    foreach (wr_log[i]) p = (p << 4) | 32'(wr_log[i]);
    return p;
  endfunction

  function automatic logic [31:0] val_pack();
    logic [31:0] p = '0;
    foreach (val_log[i]) p = (p << 1) | 32'(val_log[i]);
    return p;
  endfunction

  function automatic void clear_logs();
    wr_log.delete();
    val_log.delete();
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int dc;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_num_valid", num_valid, 0);
    check("post_reset_req_ready", req_ready, 1);

    // Fill the empty table: slots 0..3 in order.
    clear_logs();
    do_cmd(INSERT, 32'hA);
    do_cmd(INSERT, 32'hB);
    do_cmd(INSERT, 32'hC);
    do_cmd(INSERT, 32'hD);
    check("fill_idx", idx_pack(), 32'h0123);
    check("fill_vals", val_pack(), 32'hF);
    check("fill_num_valid", num_valid, 4);
    check("fill_last_done_hit", last_done_hit, 0);

    // Duplicate insert: no write, hit on slot 1, done in the cycle after the accept cycle.
    clear_logs();
    do_cmd(INSERT, 32'hB);
    check("dup_no_write", wr_log.size(), 0);
    check("dup_done_hit", last_done_hit, 1);
    check("dup_done_idx", last_done_idx, 1);
    check("dup_latency", last_done_cyc - acc_cyc, 1);

    // Invalidate slot 2, then refill the hole without touching the pointer.
    clear_logs();
    do_cmd(INVALIDATE, 32'hC);
    check("inv_idx", idx_pack(), 32'h2);
    check("inv_val", val_pack(), 32'h0);
    check("inv_done_hit", last_done_hit, 1);
    check("inv_num_valid", num_valid, 3);
    do_cmd(INSERT, 32'h20);
    check("refill_idx", idx_pack(), 32'h22);
    check("refill_vals", val_pack(), 32'h1);
    check("refill_done_idx", last_done_idx, 2);
    check("refill_latency", last_done_cyc - acc_cyc, 2);

    // Full table: round-robin victims 0,1,2,3 and back to 0.
    clear_logs();
    do_cmd(INSERT, 32'hE);
    do_cmd(INSERT, 32'hF);
    do_cmd(INSERT, 32'h10);
    do_cmd(INSERT, 32'h11);
    do_cmd(INSERT, 32'h12);
    check("evict_idx", idx_pack(), 32'h01230);
    check("evict_num_valid", num_valid, 4);

    // Flush a full table.
    clear_logs();
    dc = done_cnt;
    do_cmd(FLUSH, 32'h0);
    check("flush_idx", idx_pack(), 32'h0123);
    check("flush_vals", val_pack(), 32'h0);
    check("flush_num_valid", num_valid, 0);
    check("flush_latency", last_done_cyc - acc_cyc, 4);
    check("flush_done_count", done_cnt - dc, 1);

    // Invalidate of an absent key.
    clear_logs();
    do_cmd(INVALIDATE, 32'h99);
    check("inv_miss_no_write", wr_log.size(), 0);
    check("inv_miss_done_hit", last_done_hit, 0);
    check("inv_miss_done_idx", last_done_idx, 0);
    check("inv_miss_latency", last_done_cyc - acc_cyc, 1);

    // Reset during the WRITE cycle of an insert.
    do_cmd(INSERT, 32'h30);
    do_cmd(INSERT, 32'h31);
    clear_logs();
    dc = done_cnt;
    start_cmd(INSERT, 32'h55, ok);
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("abort_no_done", done_cnt - dc, 0);
      check("abort_no_write", wr_log.size(), 0);
      @(negedge clk);
      check("abort_num_valid", num_valid, 0);
    end
    do_cmd(INSERT, 32'h66);
    check("after_abort_idx", idx_pack(), 32'h0);
    check("after_abort_num_valid", num_valid, 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
